// File: rtl/drum_div_pkg.sv
// drum_div_pkg: shared types, default sizes and helpers for the drum_div divider.
// Related build option: DRUM_DIV_DBZ_EN (zero-divisor flag on the result).
package drum_div_pkg;

  localparam int DEF_K = 6;
  localparam int DEF_N = 8;
  localparam int DEF_M = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One's-complement magnitude of a sign-extended operand.
  // Negative values become ~v, which is -v-1 and never overflows.
  function automatic logic [31:0] ones_mag(input logic [31:0] v);
    return v[31] ? ~v : v;
  endfunction

endpackage

// File: rtl/drum_div_if.sv
// drum_div_if: operand/result handshake bundle for drum_div.
// With DRUM_DIV_DBZ_EN defined the bundle also carries the dbz flag.
interface drum_div_if
  import drum_div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
`ifdef DRUM_DIV_DBZ_EN
  logic         dbz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q
  );
`endif

endinterface

// File: rtl/drum_div_trunc.sv
// drum_div_trunc: dynamic-range truncation of the divisor magnitude.
// Keeps K significant bits from the leading one down, forces the lowest kept
// bit to one and clears everything below it. Purely combinational.
module drum_div_trunc
  import drum_div_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int M = DEF_M
) (
  input  logic [M-1:0] b_mag,
  output logic [M-1:0] d
);

  localparam int PW = $clog2(M);

  logic [PW-1:0] lead;
  logic [PW-1:0] shift;
  logic [M-1:0]  step;

  // Leading-one index: the highest set bit wins; zero input reports 0.
  always_comb begin
    lead = '0;
    for (int i = 0; i < M; i++) begin
      if (b_mag[i]) lead = PW'(i);
    end
  end

  // Short divisors pass unchanged; long ones keep a K-bit window with a forced-one LSB.
  always_comb begin
    shift = '0;
    step  = '0;
    d     = b_mag;
    if (lead > PW'(K - 1)) begin
      shift = lead - PW'(K - 1);
      step  = M'(1) << shift;
      d     = (b_mag & ~(step - M'(1))) | step;
    end
  end

endmodule

// File: rtl/drum_div.sv
// drum_div: sequential approximate signed divider using a DRUM-truncated divisor.
// Operands are taken in IDLE, one quotient bit is produced per cycle, and the
// result is held under out_valid until accepted.
// Build option DRUM_DIV_DBZ_EN adds the dbz (zero divisor) result flag.
module drum_div
  import drum_div_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input logic       clk,
  input logic       rst_n,
  drum_div_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int AW = N - 1;
  localparam int RW = M + 1;

  state_t         state_reg, state_next;
  logic [AW-1:0]  a_mag_reg;
  logic [M-1:0]   d_reg;
  logic           sign_reg;
  logic [RW-1:0]  r_reg;
  logic [CW-1:0]  cnt_reg;
  logic [AW-1:0]  quo_reg;
  logic [N-1:0]   q_reg;

  logic [AW-1:0]  a_mag;
  logic [M-1:0]   b_mag;
  logic [M-1:0]   d_trunc;
  logic           last_step;
  logic [RW:0]    r_shift;
  logic           r_ge;
  logic [AW-1:0]  quo_next;
  logic [N-1:0]   q_mag;

  // The magnitudes always have a clear MSB, so only AW bits of a are kept.
  assign a_mag = AW'(ones_mag(32'(signed'(bus.a))));
  assign b_mag = M'(ones_mag(32'(signed'(bus.b))));

  drum_div_trunc #(
    .K (K),
    .M (M)
  ) u_trunc (
    .b_mag (b_mag),
    .d     (d_trunc)
  );

  // R stays below D (< 2^(M-1)), so one extra bit on the shifted value is ample.
  assign r_shift   = {r_reg, a_mag_reg[cnt_reg]};
  assign r_ge      = r_shift >= {2'b00, d_reg};
  assign quo_next  = {quo_reg[AW-2:0], r_ge};
  assign q_mag     = {1'b0, quo_next};
  assign last_step = (state_reg == DIV) && (cnt_reg == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs; ready and valid live in disjoint states.
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = PREP;
      end
      PREP: state_next = DIV;
      DIV: begin
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, run the restoring loop, load the quotient once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_reg <= '0;
      d_reg     <= '0;
      sign_reg  <= 1'b0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      q_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_mag_reg <= a_mag;
            d_reg     <= d_trunc;
            sign_reg  <= bus.a[N-1] ^ bus.b[M-1];
          end
        end
        PREP: begin
          r_reg   <= '0;
          cnt_reg <= CW'(N - 2);
          quo_reg <= '0;
        end
        DIV: begin
          r_reg   <= r_ge ? RW'(r_shift - {2'b00, d_reg}) : RW'(r_shift);
          quo_reg <= quo_next;
          if (last_step) q_reg <= sign_reg ? ~q_mag : q_mag;
          else           cnt_reg <= cnt_reg - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.q = q_reg;

`ifdef DRUM_DIV_DBZ_EN
  logic dbz_reg;

  // Zero-divisor flag, loaded on the same edge as the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dbz_reg <= 1'b0;
    else if (last_step) dbz_reg <= (d_reg == '0);
  end

  assign bus.dbz = dbz_reg;
`endif

endmodule

// File: tb/tb_drum_div.sv
// tb_drum_div: directed and randomized checks of drum_div against an
// arithmetic reference (integer division by the truncated divisor).
// Checks dbz as well when DRUM_DIV_DBZ_EN is defined.
module tb_drum_div;
  import drum_div_pkg::*;

  localparam int K = 6;
  localparam int N = 8;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  drum_div_if #(.N(N), .M(M)) bus ();

  drum_div #(.K(K), .N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer quotient of the magnitudes by the truncated divisor.
  function automatic void ref_div(input logic [N-1:0] av, input logic [M-1:0] bv,
                                  output logic [N-1:0] qv, output logic dz);
    int am, bm, p, s, d, qm;
    am = av[N-1] ? (2**N - 1) - int'(av) : int'(av);
    bm = bv[M-1] ? (2**M - 1) - int'(bv) : int'(bv);
    p = -1;
    for (int i = 0; i < M; i++) if (bm >= (1 << i)) p = i;
    if (p > K - 1) begin
      s = p - (K - 1);
      d = ((bm / (2**s)) | 1) * (2**s);
    end else begin
      d = bm;
    end
    dz = (d == 0);
    qm = (d == 0) ? (2**(N-1) - 1) : am / d;
    qv = N'((av[N-1] ^ bv[M-1]) ? (2**N - 1) - qm : qm);
  endfunction

  // One full transaction: issue, time the result, hold under backpressure, consume.
  task automatic do_div(input logic [N-1:0] av, input logic [M-1:0] bv,
                        input logic [N-1:0] exp_q, input logic exp_dz,
                        input int hold, input bit poke);
    int lat;
    int w;
    bit ir_seen;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("idle_ready", 32'(bus.in_ready), 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    lat = 0;
    ir_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'(N));
    check_val("busy_ready", 32'(ir_seen), 32'd0);
    check_val("ready_vs_valid", 32'(bus.in_ready), 32'd0);
    check_val("q", 32'(bus.q), 32'(exp_q));
`ifdef DRUM_DIV_DBZ_EN
    check_val("dbz", 32'(bus.dbz), 32'(exp_dz));
`endif
    for (int c = 0; c < hold; c++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.a = N'($urandom);
        bus.b = M'($urandom);
      end
      @(posedge clk); #1;
      check_val("hold_q", 32'(bus.q), 32'(exp_q));
      check_val("hold_valid", 32'(bus.out_valid), 32'd1);
      check_val("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val("consume_ready", 32'(bus.in_ready), 32'd1);
    check_val("consume_valid", 32'(bus.out_valid), 32'd0);
    check_val("q_kept", 32'(bus.q), 32'(exp_q));
    $display("txn a=%02h b=%02h q=%02h exp=%02h exp_dz=%0d lat=%0d hold=%0d",
             av, bv, bus.q, exp_q, exp_dz, lat, hold);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic         dz;
  } vec_t;

  vec_t dir_vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] ra;
    logic [M-1:0] rb;
    logic [N-1:0] rq;
    logic         rdz;
    logic [M-1:0] edge_b[5];
    bit ov_seen;

    dir_vecs[0] = '{8'd100, 8'd7,   8'h0E, 1'b0};
    dir_vecs[1] = '{8'd126, 8'd127, 8'h01, 1'b0};
    dir_vecs[2] = '{8'd127, 8'd64,  8'h01, 1'b0};
    dir_vecs[3] = '{8'h20,  8'hFC,  8'hF5, 1'b0};
    dir_vecs[4] = '{8'h80,  8'd64,  8'hFE, 1'b0};
    dir_vecs[5] = '{8'd5,   8'h00,  8'h7F, 1'b1};
    dir_vecs[6] = '{8'd5,   8'hFF,  8'h80, 1'b1};
    edge_b[0] = 8'h00;
    edge_b[1] = 8'hFF;
    edge_b[2] = 8'h7F;
    edge_b[3] = 8'h80;
    edge_b[4] = 8'h01;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    check_val("rst_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_q", 32'(bus.q), 32'd0);
`ifdef DRUM_DIV_DBZ_EN
    check_val("rst_dbz", 32'(bus.dbz), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_vecs[i])
      do_div(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].q, dir_vecs[i].dz, 0, 1'b0);

    // Long backpressure with operand pokes that must be ignored.
    ref_div(8'h55, 8'h03, rq, rdz);
    do_div(8'h55, 8'h03, rq, rdz, 20, 1'b1);

    // Reset in the middle of DIV: prior quotient is nonzero.
    do_div(8'd100, 8'd7, 8'h0E, 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.a = 8'd126;
    bus.b = 8'd127;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_q", 32'(bus.q), 32'd0);
    check_val("midrst_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check_val("midrst_no_pulse", 32'(ov_seen), 32'd0);
    do_div(8'd100, 8'd7, 8'h0E, 1'b0, 0, 1'b0);

    // Randomized operands, with periodic extreme divisors.
    for (int t = 0; t < 40; t++) begin
      ra = N'($urandom);
      rb = (t % 8 == 0) ? edge_b[$urandom_range(0, 4)] : M'($urandom);
      ref_div(ra, rb, rq, rdz);
      do_div(ra, rb, rq, rdz, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
